snn_weight_fetch: RTL

SNN_WEIGHT_FETCH -- requirements
Module: snn_weight_fetch

---
 rtl/snn_pkg.sv | 17 +
 rtl/snn_byte_unpacker.sv | 44 ++++
 rtl/snn_weight_fetch.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN weight fetch block.
// Holds the fetch FSM state encoding and the Wishbone bus widths.
package snn_pkg;

  localparam int WB_ADR_W = 32;
  localparam int WB_DAT_W = 32;
  localparam logic [3:0] SEL_ALL = 4'hF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_UNPACK = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/snn_byte_unpacker.sv
// Holds one fetched 32-bit word and streams it out LSB-first, one byte per handshake.
// The buffer shifts right on every transfer, so the presented byte is always buf_r[7:0].
module snn_byte_unpacker
  import snn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [WB_DAT_W-1:0] data,
  input  logic                weight_ready,
  output logic [7:0]          weight,
  output logic                weight_valid,
  output logic                word_done
);

  logic [WB_DAT_W-1:0] buf_r;
  logic [1:0]          idx_r;
  logic                valid_r;
  logic                xfer_s;

  assign xfer_s = valid_r & weight_ready;

  // Word buffer, byte index and valid flag; a stalled byte stays put until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_r   <= {WB_DAT_W{1'b0}};
      idx_r   <= 2'd0;
      valid_r <= 1'b0;
    end else if (load) begin
      buf_r   <= data;
      idx_r   <= 2'd0;
      valid_r <= 1'b1;
    end else if (xfer_s) begin
      buf_r   <= {8'h00, buf_r[WB_DAT_W-1:8]};
      idx_r   <= idx_r + 2'd1;
      valid_r <= (idx_r != 2'd3);
    end
  end

  assign weight       = buf_r[7:0];
  assign weight_valid = valid_r;
  assign word_done    = xfer_s & (idx_r == 2'd3);

endmodule

// File: rtl/snn_weight_fetch.sv
// Fetches count_i 32-bit weight words over a Wishbone classic read bus and
// hands them to the neuron datapath as a byte stream.
module snn_weight_fetch
  import snn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADR_STEP       = 4
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                start_i,
  input  logic [WB_ADR_W-1:0] base_adr_i,
  input  logic [15:0]         count_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [3:0]          wbm_sel_o,
  output logic [WB_ADR_W-1:0] wbm_adr_o,
  input  logic [WB_DAT_W-1:0] wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic [7:0]          weight_o,
  output logic                weight_valid_o,
  input  logic                weight_ready_i
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t              state_r;
  logic [WB_ADR_W-1:0] adr_r;
  logic [15:0]         cnt_r;
  logic [TW-1:0]       wait_r;
  logic                cyc_r;
  logic                busy_r;
  logic                done_r;
  logic                err_r;
  logic                load_s;
  logic                word_done_s;
  logic                timeout_s;

  // An ack that coincides with err is not a valid word and must not load the buffer.
  assign load_s    = (state_r == ST_REQ) && wbm_ack_i && !wbm_err_i;
  assign timeout_s = (wait_r == TW'(TIMEOUT_CYCLES - 1));

  // Fetch sequencer with registered bus and status outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r <= ST_IDLE;
      adr_r   <= {WB_ADR_W{1'b0}};
      cnt_r   <= 16'd0;
      wait_r  <= {TW{1'b0}};
      cyc_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            err_r  <= 1'b0;
            busy_r <= 1'b1;
            if (count_i != 16'd0) begin
              adr_r   <= base_adr_i;
              cnt_r   <= count_i;
              wait_r  <= {TW{1'b0}};
              cyc_r   <= 1'b1;
              state_r <= ST_REQ;
            end else begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (wbm_err_i) begin
            cyc_r   <= 1'b0;
            state_r <= ST_ERR;
          end else if (wbm_ack_i) begin
            cyc_r   <= 1'b0;
            state_r <= ST_UNPACK;
          end else if (timeout_s) begin
            cyc_r   <= 1'b0;
            state_r <= ST_ERR;
          end else begin
            wait_r <= wait_r + TW'(1);
          end
        end
        ST_UNPACK: begin
          if (word_done_s) begin
            cnt_r <= cnt_r - 16'd1;
            if (cnt_r == 16'd1) begin
              done_r  <= 1'b1;
              state_r <= ST_DONE;
            end else begin
              adr_r   <= adr_r + WB_ADR_W'(ADR_STEP);
              wait_r  <= {TW{1'b0}};
              cyc_r   <= 1'b1;
              state_r <= ST_REQ;
            end
          end
        end
        ST_ERR: begin
          err_r   <= 1'b1;
          done_r  <= 1'b1;
          state_r <= ST_DONE;
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          cyc_r   <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  snn_byte_unpacker u_unpacker (
    .clk          (wb_clk_i),
    .rst_n        (wb_rst_ni),
    .load         (load_s),
    .data         (wbm_dat_i),
    .weight_ready (weight_ready_i),
    .weight       (weight_o),
    .weight_valid (weight_valid_o),
    .word_done    (word_done_s)
  );

  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign err_o     = err_r;
  assign wbm_cyc_o = cyc_r;
  assign wbm_stb_o = cyc_r;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = SEL_ALL;
  assign wbm_adr_o = adr_r;

endmodule
